serial_operand_serializer: RTL and testbench

Converts pairs of WIDTH-bit parallel operands into the LSB-first bit-serial stream consumed by the serial adder stage. Each operand pair is accepted through a valid/ready handshake. Each pair is then emitted one bit per cycle on `a`/`b`, qualified by `vld`, with `last` marking the MSB. A one-word pending buffer lets the next pair be accepted while the current one is still shifting. This gives back-to-back operation with no idle cycle between words.

---
 rtl/serial_operand_serializer_pkg.sv | 16 +
 rtl/serial_operand_serializer_if.sv | 26 ++
 rtl/serial_operand_serializer_shift_core.sv | 57 +++++
 rtl/serial_operand_serializer.sv | 58 +++++
 tb/tb_serial_operand_serializer.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_operand_serializer_pkg.sv
// rtl/serial_operand_serializer_pkg.sv - shared types and sizing for the operand serializer
package serial_pkg;

  localparam int SERIAL_WIDTH_DEFAULT = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // A 1-bit floor keeps the counter legal even for the minimum width.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_operand_serializer_if.sv
// rtl/serial_operand_serializer_if.sv - parallel operand input and serial bit output bundle
interface serial_operand_serializer_if #(
  parameter int WIDTH = 8
);

  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             stall;
  logic             vld;
  logic             a;
  logic             b;
  logic             last;

  modport master (
    output in_vld, in_a, in_b, stall,
    input  in_rdy, vld, a, b, last
  );

  modport slave (
    input  in_vld, in_a, in_b, stall,
    output in_rdy, vld, a, b, last
  );

endinterface

// File: rtl/serial_operand_serializer_shift_core.sv
// rtl/serial_operand_serializer_shift_core.sv - LSB-first shifter with bit counter and last flag
module serial_shift_core
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  input  logic             advance,
  output logic             busy,
  output logic             vld,
  output logic             a,
  output logic             b,
  output logic             last
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;

  assign busy = (state == S_SHIFT);
  assign vld  = busy & advance;
  assign a    = busy & sh_a[0];
  assign b    = busy & sh_b[0];
  assign last = vld & (cnt == CW'(WIDTH - 1));

  // A load always wins: it is either a fresh start or the seamless refill on the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
    end else if (load) begin
      state <= S_SHIFT;
      sh_a  <= load_a;
      sh_b  <= load_b;
      cnt   <= '0;
    end else if (vld) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      if (last) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/serial_operand_serializer.sv
// rtl/serial_operand_serializer.sv - operand pair serializer with one-word pending buffer
module serial_operand_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input logic                        clk,
  input logic                        rst_n,
  serial_operand_serializer_if.slave bus
);

  logic [WIDTH-1:0] pend_a;
  logic [WIDTH-1:0] pend_b;
  logic             pend_full;
  logic             busy;
  logic             last;
  logic             xfer;
  logic             load;

  assign bus.in_rdy = ~pend_full;
  assign xfer       = bus.in_vld & ~pend_full;

  // Pending word has priority on the MSB; in_rdy is low then, so no transfer can collide.
  assign load = (~busy & xfer) | (last & (pend_full | xfer));

  serial_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .load_a (pend_full ? pend_a : bus.in_a),
    .load_b (pend_full ? pend_b : bus.in_b),
    .advance(~bus.stall),
    .busy   (busy),
    .vld    (bus.vld),
    .a      (bus.a),
    .b      (bus.b),
    .last   (bus.last)
  );

  assign last = bus.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_a    <= '0;
      pend_b    <= '0;
      pend_full <= 1'b0;
    end else if (last && pend_full) begin
      pend_full <= 1'b0;
    end else if (xfer && busy && !last) begin
      pend_a    <= bus.in_a;
      pend_b    <= bus.in_b;
      pend_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// tb/tb_serial_operand_serializer.sv - directed self-checking bench for the operand serializer
module tb_serial_operand_serializer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  serial_operand_serializer_if #(.WIDTH(4)) bus ();

  serial_operand_serializer #(
    .WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.in_vld = 1'b0;
    bus.in_a   = '0;
    bus.in_b   = '0;
    bus.stall  = 1'b0;
    step();
    step();
    #1;
    n_checks++;
    if ({bus.in_rdy, bus.vld, bus.a, bus.b, bus.last} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy,vld,a,b,last=%b expected 10000",
               {bus.in_rdy, bus.vld, bus.a, bus.b, bus.last});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_word();
    logic [3:0] ea;
    logic [3:0] eb;
    ea = 4'b1011;
    eb = 4'b0110;
    bus.in_vld = 1'b1;
    bus.in_a   = 4'b1011;
    bus.in_b   = 4'b0110;
    #1;
    n_checks++;
    if (bus.vld !== 1'b0 || bus.in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pre: got vld=%b rdy=%b expected vld=0 rdy=1", bus.vld, bus.in_rdy);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      bus.in_vld = 1'b0;
      #1;
      n_checks++;
      if (bus.vld !== 1'b1 || bus.a !== ea[i] || bus.b !== eb[i] || bus.last !== (i == 3)) begin
        n_fail++;
        $display("FAIL single_bit%0d: got vld,a,b,last=%b%b%b%b expected 1%b%b%b",
                 i, bus.vld, bus.a, bus.b, bus.last, ea[i], eb[i], (i == 3));
      end
      step();
    end
    #1;
    n_checks++;
    if (bus.vld !== 1'b0 || bus.last !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: got vld=%b last=%b expected 0 0", bus.vld, bus.last);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] erdy;
    logic [7:0] el;
    ea   = 8'b0011_1111;
    eb   = 8'b1100_0001;
    erdy = 8'b1111_0001;
    el   = 8'b1000_1000;
    bus.in_vld = 1'b1;
    bus.in_a   = 4'hF;
    bus.in_b   = 4'h1;
    step();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        bus.in_a = 4'h3;
        bus.in_b = 4'hC;
      end else begin
        bus.in_vld = 1'b0;
      end
      #1;
      n_checks++;
      if (bus.vld !== 1'b1 || bus.a !== ea[c] || bus.b !== eb[c] ||
          bus.last !== el[c] || bus.in_rdy !== erdy[c]) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got vld,a,b,last,rdy=%b%b%b%b%b expected 1%b%b%b%b",
                 c, bus.vld, bus.a, bus.b, bus.last, bus.in_rdy, ea[c], eb[c], el[c], erdy[c]);
      end
      step();
    end
    #1;
    n_checks++;
    if (bus.vld !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got vld=%b expected 0", bus.vld);
    end
  endtask

  task automatic test_stall();
    logic [9:0] ev;
    logic [9:0] ea;
    logic [9:0] eb;
    logic [9:0] el;
    logic [9:0] erdy;
    logic [9:0] sp;
    ev   = 10'b1111110011;
    ea   = 10'b0110100001;
    eb   = 10'b1010000011;
    el   = 10'b1000100000;
    erdy = 10'b1111000111;
    sp   = 10'b0000001100;
    bus.in_vld = 1'b1;
    bus.in_a   = 4'b1001;
    bus.in_b   = 4'b0011;
    step();
    for (int c = 0; c < 10; c++) begin
      bus.stall = sp[c];
      if (c == 2) begin
        bus.in_vld = 1'b1;
        bus.in_a   = 4'b0110;
        bus.in_b   = 4'b1010;
      end else begin
        bus.in_vld = 1'b0;
      end
      #1;
      n_checks++;
      if (bus.vld !== ev[c] || bus.a !== ea[c] || bus.b !== eb[c] ||
          bus.last !== el[c] || bus.in_rdy !== erdy[c]) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got vld,a,b,last,rdy=%b%b%b%b%b expected %b%b%b%b%b",
                 c, bus.vld, bus.a, bus.b, bus.last, bus.in_rdy, ev[c], ea[c], eb[c], el[c], erdy[c]);
      end
      step();
    end
    bus.stall = 1'b0;
    #1;
    n_checks++;
    if (bus.vld !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_end: got vld=%b expected 0", bus.vld);
    end
  endtask

  task automatic test_pending_full();
    logic [11:0] ea;
    logic [11:0] eb;
    logic [11:0] erdy;
    logic [11:0] el;
    ea   = 12'h9C5;
    eb   = 12'h63A;
    erdy = 12'hF11;
    el   = 12'h888;
    bus.in_vld = 1'b1;
    bus.in_a   = 4'h5;
    bus.in_b   = 4'hA;
    step();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        bus.in_a = 4'hC;
        bus.in_b = 4'h3;
      end else if (c <= 4) begin
        bus.in_a = 4'h9;
        bus.in_b = 4'h6;
      end else begin
        bus.in_vld = 1'b0;
      end
      #1;
      n_checks++;
      if (bus.vld !== 1'b1 || bus.a !== ea[c] || bus.b !== eb[c] ||
          bus.last !== el[c] || bus.in_rdy !== erdy[c]) begin
        n_fail++;
        $display("FAIL pend_cycle%0d: got vld,a,b,last,rdy=%b%b%b%b%b expected 1%b%b%b%b",
                 c, bus.vld, bus.a, bus.b, bus.last, bus.in_rdy, ea[c], eb[c], el[c], erdy[c]);
      end
      step();
    end
    #1;
    n_checks++;
    if (bus.vld !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_end: got vld=%b expected 0", bus.vld);
    end
  endtask

  task automatic test_bypass_on_last();
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] el;
    ea = 8'hE3;
    eb = 8'h85;
    el = 8'h88;
    bus.in_vld = 1'b1;
    bus.in_a   = 4'b0011;
    bus.in_b   = 4'b0101;
    step();
    for (int c = 0; c < 8; c++) begin
      if (c == 3) begin
        bus.in_vld = 1'b1;
        bus.in_a   = 4'b1110;
        bus.in_b   = 4'b1000;
      end else begin
        bus.in_vld = 1'b0;
      end
      #1;
      n_checks++;
      if (bus.vld !== 1'b1 || bus.a !== ea[c] || bus.b !== eb[c] ||
          bus.last !== el[c] || bus.in_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL bypass_cycle%0d: got vld,a,b,last,rdy=%b%b%b%b%b expected 1%b%b%b1",
                 c, bus.vld, bus.a, bus.b, bus.last, bus.in_rdy, ea[c], eb[c], el[c]);
      end
      step();
    end
    #1;
    n_checks++;
    if (bus.vld !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_end: got vld=%b expected 0", bus.vld);
    end
  endtask

  task automatic test_mid_word_reset();
    logic [3:0] ea;
    logic [3:0] eb;
    ea = 4'b0110;
    eb = 4'b1001;
    bus.in_vld = 1'b1;
    bus.in_a   = 4'hF;
    bus.in_b   = 4'hF;
    step();
    bus.in_a = 4'h3;
    bus.in_b = 4'h3;
    #1;
    n_checks++;
    if (bus.vld !== 1'b1 || bus.a !== 1'b1) begin
      n_fail++;
      $display("FAIL mreset_bit0: got vld=%b a=%b expected 1 1", bus.vld, bus.a);
    end
    step();
    bus.in_vld = 1'b0;
    #1;
    n_checks++;
    if (bus.vld !== 1'b1 || bus.in_rdy !== 1'b0 || bus.last !== 1'b0) begin
      n_fail++;
      $display("FAIL mreset_bit1: got vld=%b rdy=%b last=%b expected 1 0 0",
               bus.vld, bus.in_rdy, bus.last);
    end
    step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_rdy, bus.vld, bus.a, bus.b, bus.last} !== 5'b10000) begin
      n_fail++;
      $display("FAIL mreset_async: got rdy,vld,a,b,last=%b expected 10000",
               {bus.in_rdy, bus.vld, bus.a, bus.b, bus.last});
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (bus.vld !== 1'b0 || bus.last !== 1'b0 || bus.in_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL mreset_quiet%0d: got vld=%b last=%b rdy=%b expected 0 0 1",
                 c, bus.vld, bus.last, bus.in_rdy);
      end
      step();
    end
    bus.in_vld = 1'b1;
    bus.in_a   = 4'b0110;
    bus.in_b   = 4'b1001;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.in_vld = 1'b0;
      #1;
      n_checks++;
      if (bus.vld !== 1'b1 || bus.a !== ea[i] || bus.b !== eb[i] || bus.last !== (i == 3)) begin
        n_fail++;
        $display("FAIL mreset_new_bit%0d: got vld,a,b,last=%b%b%b%b expected 1%b%b%b",
                 i, bus.vld, bus.a, bus.b, bus.last, ea[i], eb[i], (i == 3));
      end
      step();
    end
    #1;
    n_checks++;
    if (bus.vld !== 1'b0) begin
      n_fail++;
      $display("FAIL mreset_new_end: got vld=%b expected 0", bus.vld);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_word();
    step();
    test_back_to_back();
    step();
    test_stall();
    step();
    test_pending_full();
    step();
    test_bypass_on_last();
    step();
    test_mid_word_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
